vend_ctrl_multi: RTL and testbench
==================================

// Module: vend_ctrl_multi
// PURPOSE
//  Parametrised newspaper/vending controller: accumulates coin credit toward a configurable
//  price, pulses the dispense output, returns change over a valid/ack handshake, supports
//  cancel/refund, and rejects coins it cannot hold. Sits between the coin acceptor and the
//  dispenser/change-hopper drivers. All amounts are in 5-cent units.
// PARAMETERS
//  CREDIT_W    4   width of credit and change_amt
//  PRICE       3   item price (units); legal range 1..MAX_CREDIT
//  MAX_CREDIT  8   largest credit held; must be < 2**CREDIT_W
//  VAL_A       1   value of coin code 2'b01 (5c)
//  VAL_B       2   value of coin code 2'b10 (10c)
//  VAL_C       5   value of coin code 2'b11 (25c)
// PORTS
//  clock        in   1         system clock, rising edge
//  reset        in   1         synchronous, active-high
//  coin         in   2         00 none, 01/10/11 coin A/B/C; sampled every cycle
//  cancel       in   1         refund request
//  change_ack   in   1         hopper has taken change_amt
//  newspaper    out  1         dispense, 1-cycle pulse
//  change_valid out  1         change_amt is valid; held until change_ack
//  change_amt   out  CREDIT_W  change to return (units)
//  credit       out  CREDIT_W  current accumulated credit
//  coin_reject  out  1         1-cycle pulse: last sampled coin not accepted (return it)
// BEHAVIOUR
//  - States: IDLE (credit==0), ACCUM, VEND, CHANGE. Illegal encoding -> IDLE.
//  - Reset: state IDLE; credit, change_amt, newspaper, change_valid, coin_reject all 0.
//    Reset mid-VEND/CHANGE discards credit and pending change; no pulse is emitted.
//  - IDLE/ACCUM, coin!=00, cancel=0: sum = credit + VAL.
//    * sum > MAX_CREDIT: coin_reject=1 next cycle, credit unchanged, state unchanged.
//    * sum >= PRICE: credit<=sum, state<=VEND next cycle.
//    * else: credit<=sum, state<=ACCUM.
//    Sum is computed CREDIT_W+1 bits wide; no wrap-around.
//  - Latency: coin sampled at edge n -> credit updated and visible after edge n;
//    newspaper high for the cycle following edge n if price is reached.
//  - cancel in IDLE/ACCUM: credit>0 -> change_amt<=credit, credit<=0, state CHANGE;
//    credit==0 -> ignored. Coin in the same cycle as cancel -> coin_reject, not credited.
//  - VEND (exactly 1 cycle): newspaper=1 (decoded from state). rem=credit-PRICE.
//    rem==0 -> IDLE, credit<=0. rem>0 -> change_amt<=rem, credit<=0, state CHANGE.
//  - CHANGE: change_valid=1; change_amt stable until change_ack sampled high.
//    ack -> IDLE, change_valid 0 and change_amt 0 in the next cycle.
//    ack outside CHANGE is ignored.
//  - Any coin in VEND or CHANGE -> coin_reject pulse; cancel is ignored.
//  - newspaper and change_valid are never both 1. coin_reject is registered: it is
//    asserted the cycle after the offending coin.
// TESTING (defaults unless noted)
//  1. coin 01,01,01 on consecutive cycles -> credit 1,2,3; newspaper 1 cycle;
//     change_valid never 1; returns to IDLE with credit 0.
//  2. coin 10,10 -> credit 4 -> newspaper pulse -> change_valid with change_amt=1;
//     ack withheld 3 cycles keeps it stable; ack -> IDLE.
//  3. coin 11 from IDLE -> newspaper pulse, then change_amt=2; coin 01 during CHANGE
//     -> coin_reject pulse, change_amt stays 2.
//  4. coin 01, then cancel -> change_amt=1, newspaper never asserted; cancel+coin 10
//     in the same cycle -> refund of prior credit only, coin_reject pulse.
//  5. PRICE=8: coin 11,10 (credit 7), then coin 11 -> coin_reject, credit stays 7;
//     coin 01 -> credit 8, vend, no change.
//  6. reset asserted during CHANGE (amt 2) -> next cycle all outputs 0, state IDLE;
//     later ack has no effect.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// Coin-operated newspaper vending controller: accumulates credit, pulses dispense,
// returns change over a valid/ack handshake, supports cancel/refund and coin rejection.
module vend_ctrl_multi #(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 8,
    parameter int VAL_A      = 1,
    parameter int VAL_B      = 2,
    parameter int VAL_C      = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                newspaper,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject
);

    localparam int SUM_W = CREDIT_W + 1;

    typedef logic [SUM_W-1:0]    sum_t;
    typedef logic [CREDIT_W-1:0] amt_t;

    localparam sum_t MAX_S   = sum_t'(MAX_CREDIT);
    localparam sum_t PRICE_S = sum_t'(PRICE);
    localparam amt_t PRICE_A = amt_t'(PRICE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    state_e r_state;
    amt_t   r_credit;
    amt_t   r_change_amt;
    logic   r_coin_reject;

    state_e w_nxt_state;
    amt_t   w_nxt_credit;
    amt_t   w_nxt_change_amt;
    logic   w_nxt_coin_reject;
    sum_t   w_coin_val;
    sum_t   w_sum;
    amt_t   w_rem;
    logic   w_coin_present;

    // Coin value decode; one bit wider than credit so an oversize sum never wraps.
    always_comb begin
        case (coin)
            2'b01:   w_coin_val = sum_t'(VAL_A);
            2'b10:   w_coin_val = sum_t'(VAL_B);
            2'b11:   w_coin_val = sum_t'(VAL_C);
            default: w_coin_val = '0;
        endcase
    end

    assign w_coin_present = (coin != 2'b00);
    assign w_sum          = {1'b0, r_credit} + w_coin_val;
    assign w_rem          = r_credit - PRICE_A;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        w_nxt_state       = r_state;
        w_nxt_credit      = r_credit;
        w_nxt_change_amt  = r_change_amt;
        w_nxt_coin_reject = 1'b0;

        case (r_state)
            IDLE, ACCUM: begin
                if (cancel) begin
                    // A coin arriving with cancel is handed back, never credited.
                    w_nxt_coin_reject = w_coin_present;
                    if (r_credit != '0) begin
                        w_nxt_change_amt = r_credit;
                        w_nxt_credit     = '0;
                        w_nxt_state      = CHANGE;
                    end
                end else if (w_coin_present) begin
                    if (w_sum > MAX_S) begin
                        w_nxt_coin_reject = 1'b1;
                    end else if (w_sum >= PRICE_S) begin
                        w_nxt_credit = w_sum[CREDIT_W-1:0];
                        w_nxt_state  = VEND;
                    end else begin
                        w_nxt_credit = w_sum[CREDIT_W-1:0];
                        w_nxt_state  = ACCUM;
                    end
                end
            end

            VEND: begin
                w_nxt_coin_reject = w_coin_present;
                w_nxt_credit      = '0;
                if (w_rem == '0) begin
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_change_amt = w_rem;
                    w_nxt_state      = CHANGE;
                end
            end

            CHANGE: begin
                w_nxt_coin_reject = w_coin_present;
                if (change_ack) begin
                    w_nxt_change_amt = '0;
                    w_nxt_state      = IDLE;
                end
            end

            default: begin
                w_nxt_state      = IDLE;
                w_nxt_credit     = '0;
                w_nxt_change_amt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_change_amt  <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_credit      <= w_nxt_credit;
            r_change_amt  <= w_nxt_change_amt;
            r_coin_reject <= w_nxt_coin_reject;
        end
    end

    // Dispense and change handshake are state decodes, so they are mutually exclusive.
    assign newspaper    = (r_state == VEND);
    assign change_valid = (r_state == CHANGE);
    assign change_amt   = r_change_amt;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: default-price instance plus a PRICE=8 instance.
module tb_vend_ctrl_multi;

    typedef enum int {EV_VEND, EV_CHANGE, EV_REJECT} ev_e;
    typedef struct {
        ev_e kind;
        int  val;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic [1:0] d1_coin = 2'b00;
    logic       d1_cancel = 1'b0;
    logic       d1_ack = 1'b0;
    logic       d1_newspaper, d1_change_valid, d1_coin_reject;
    logic [3:0] d1_change_amt, d1_credit;

    logic [1:0] d2_coin = 2'b00;
    logic       d2_cancel = 1'b0;
    logic       d2_ack = 1'b0;
    logic       d2_newspaper, d2_change_valid, d2_coin_reject;
    logic [3:0] d2_change_amt, d2_credit;

    ev_t q1[$];
    ev_t q2[$];
    int  errors = 0;
    int  checks = 0;

    logic       p1_cv = 1'b0;
    logic [3:0] h1_amt = '0;
    logic       p2_cv = 1'b0;
    logic [3:0] h2_amt = '0;

    vend_ctrl_multi u_dut1 (
        .clock        (clock),
        .reset        (reset),
        .coin         (d1_coin),
        .cancel       (d1_cancel),
        .change_ack   (d1_ack),
        .newspaper    (d1_newspaper),
        .change_valid (d1_change_valid),
        .change_amt   (d1_change_amt),
        .credit       (d1_credit),
        .coin_reject  (d1_coin_reject)
    );

    vend_ctrl_multi #(.PRICE(8)) u_dut2 (
        .clock        (clock),
        .reset        (reset),
        .coin         (d2_coin),
        .cancel       (d2_cancel),
        .change_ack   (d2_ack),
        .newspaper    (d2_newspaper),
        .change_valid (d2_change_valid),
        .change_amt   (d2_change_amt),
        .credit       (d2_credit),
        .coin_reject  (d2_coin_reject)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input ev_e kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        if (sel == 1) q1.push_back(e);
        else          q2.push_back(e);
    endtask

    task automatic sb_pop(input int sel, input ev_e kind, input int val, input string name);
        ev_t e;
        if ((sel == 1 && q1.size() == 0) || (sel == 2 && q2.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event kind %0d value %0d", name, int'(kind), val);
        end else begin
            if (sel == 1) e = q1.pop_front();
            else          e = q2.pop_front();
            check({name, " kind"}, int'(kind), int'(e.kind));
            check({name, " value"}, val, e.val);
        end
    endtask

    // Monitors: observed events are popped against the expectations queued by the stimulus.
    always @(negedge clock) begin
        if (d1_newspaper) begin
            check("d1 vend/change exclusive", {31'd0, d1_change_valid}, 0);
            sb_pop(1, EV_VEND, int'(d1_credit), "d1 vend");
        end
        if (d1_change_valid && !p1_cv) begin
            sb_pop(1, EV_CHANGE, int'(d1_change_amt), "d1 change");
            h1_amt <= d1_change_amt;
        end else if (d1_change_valid) begin
            check("d1 change_amt stable", {28'd0, d1_change_amt}, {28'd0, h1_amt});
        end
        if (d1_coin_reject) sb_pop(1, EV_REJECT, int'(d1_credit), "d1 reject");
        p1_cv <= d1_change_valid;
    end

    always @(negedge clock) begin
        if (d2_newspaper) begin
            check("d2 vend/change exclusive", {31'd0, d2_change_valid}, 0);
            sb_pop(2, EV_VEND, int'(d2_credit), "d2 vend");
        end
        if (d2_change_valid && !p2_cv) begin
            sb_pop(2, EV_CHANGE, int'(d2_change_amt), "d2 change");
            h2_amt <= d2_change_amt;
        end else if (d2_change_valid) begin
            check("d2 change_amt stable", {28'd0, d2_change_amt}, {28'd0, h2_amt});
        end
        if (d2_coin_reject) sb_pop(2, EV_REJECT, int'(d2_credit), "d2 reject");
        p2_cv <= d2_change_valid;
    end

    // One clock with the given inputs on the selected instance; returns 1 time unit after the edge.
    task automatic cyc(input int sel, input logic [1:0] c, input logic can, input logic ack);
        if (sel == 1) begin
            d1_coin = c; d1_cancel = can; d1_ack = ack;
        end else begin
            d2_coin = c; d2_cancel = can; d2_ack = ack;
        end
        @(posedge clock);
        #1;
        d1_coin = 2'b00; d1_cancel = 1'b0; d1_ack = 1'b0;
        d2_coin = 2'b00; d2_cancel = 1'b0; d2_ack = 1'b0;
    endtask

    task automatic chk1(input string n, input logic [3:0] cred, input logic nw,
                        input logic cv, input logic [3:0] amt, input logic rej);
        check({n, " credit"},       {28'd0, d1_credit},       {28'd0, cred});
        check({n, " newspaper"},    {31'd0, d1_newspaper},    {31'd0, nw});
        check({n, " change_valid"}, {31'd0, d1_change_valid}, {31'd0, cv});
        check({n, " change_amt"},   {28'd0, d1_change_amt},   {28'd0, amt});
        check({n, " coin_reject"},  {31'd0, d1_coin_reject},  {31'd0, rej});
    endtask

    task automatic chk2(input string n, input logic [3:0] cred, input logic nw,
                        input logic cv, input logic rej);
        check({n, " credit"},       {28'd0, d2_credit},       {28'd0, cred});
        check({n, " newspaper"},    {31'd0, d2_newspaper},    {31'd0, nw});
        check({n, " change_valid"}, {31'd0, d2_change_valid}, {31'd0, cv});
        check({n, " coin_reject"},  {31'd0, d2_coin_reject},  {31'd0, rej});
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk1("reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk2("reset d2", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Exact price with three small coins.
        push(1, EV_VEND, 3);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t1 c1", 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t1 c2", 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t1 c3", 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t1 idle", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Overpay by one unit, ack withheld for three cycles.
        push(1, EV_VEND, 4);
        push(1, EV_CHANGE, 1);
        cyc(1, 2'b10, 1'b0, 1'b0); chk1("t2 c1", 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b10, 1'b0, 1'b0); chk1("t2 vend", 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t2 change", 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b00, 1'b0, 1'b0);
            chk1("t2 hold", 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        end
        cyc(1, 2'b00, 1'b0, 1'b1); chk1("t2 ack", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Large coin from idle, then a coin during change is rejected.
        push(1, EV_VEND, 5);
        push(1, EV_CHANGE, 2);
        push(1, EV_REJECT, 0);
        cyc(1, 2'b11, 1'b0, 1'b0); chk1("t3 vend", 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t3 change", 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t3 reject", 4'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t3 after", 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b1); chk1("t3 ack", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Cancel with zero credit is ignored; cancel with credit refunds it.
        cyc(1, 2'b00, 1'b1, 1'b0); chk1("t4 cancel0", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        push(1, EV_CHANGE, 1);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t4 c1", 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b1, 1'b0); chk1("t4 refund", 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b1); chk1("t4 ack", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        push(1, EV_CHANGE, 1);
        push(1, EV_REJECT, 0);
        cyc(1, 2'b01, 1'b0, 1'b0); chk1("t4 c2", 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b10, 1'b1, 1'b0); chk1("t4 cancel+coin", 4'd0, 1'b0, 1'b1, 4'd1, 1'b1);
        cyc(1, 2'b00, 1'b0, 1'b1); chk1("t4 ack2", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // PRICE=8 instance: overflow coin rejected, exact fill vends with no change.
        push(2, EV_REJECT, 7);
        push(2, EV_VEND, 8);
        cyc(2, 2'b11, 1'b0, 1'b0); chk2("t5 c1", 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(2, 2'b10, 1'b0, 1'b0); chk2("t5 c2", 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(2, 2'b11, 1'b0, 1'b0); chk2("t5 overflow", 4'd7, 1'b0, 1'b0, 1'b1);
        cyc(2, 2'b01, 1'b0, 1'b0); chk2("t5 vend", 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(2, 2'b00, 1'b0, 1'b0); chk2("t5 idle", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(2, 2'b00, 1'b0, 1'b0); chk2("t5 no change", 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of returning change, then a stray ack.
        push(1, EV_VEND, 5);
        push(1, EV_CHANGE, 2);
        cyc(1, 2'b11, 1'b0, 1'b0); chk1("t6 vend", 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t6 change", 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk1("t6 reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        cyc(1, 2'b00, 1'b0, 1'b1); chk1("t6 stray ack", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1, 2'b00, 1'b0, 1'b0); chk1("t6 idle", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        repeat (3) cyc(1, 2'b00, 1'b0, 1'b0);
        check("d1 queue drained", q1.size(), 0);
        check("d2 queue drained", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
